term_writer: RTL



---
 rtl/term_writer_if.sv | 33 +++
 rtl/term_writer.sv | 159 +++++++++++++++
 2 files changed

// File: rtl/term_writer_if.sv
// Byte-stream input and vram write-port signals shared by term_writer and its driver.
interface term_writer_if;
    logic       in_ready;
    logic       in_valid;
    logic [7:0] in_char;
    logic       vram_write_ready;
    logic       vram_write_valid;
    logic [4:0] vram_write_row;
    logic [6:0] vram_write_col;
    logic [7:0] vram_write_char;

    modport slave (
        output in_ready,
        input  in_valid,
        input  in_char,
        input  vram_write_ready,
        output vram_write_valid,
        output vram_write_row,
        output vram_write_col,
        output vram_write_char
    );

    modport master (
        input  in_ready,
        output in_valid,
        output in_char,
        output vram_write_ready,
        input  vram_write_valid,
        input  vram_write_row,
        input  vram_write_col,
        input  vram_write_char
    );
endinterface

// File: rtl/term_writer.sv
// Terminal character writer: turns a byte stream into vram writes, tracks the cursor
// and advances the display's top_row so the row ring scrolls like a terminal.
module term_writer #(
    parameter int          COLS  = 100,
    parameter int          ROWS  = 32,
    parameter logic [7:0]  BLANK = 8'h20
) (
    input  logic        clk,
    input  logic        reset_low,
    term_writer_if.slave bus,
    output logic [4:0]  top_row,
    output logic [4:0]  cursor_row,
    output logic [6:0]  cursor_col
);

    localparam logic [1:0] S_IDLE      = 2'd0;
    localparam logic [1:0] S_PUT       = 2'd1;
    localparam logic [1:0] S_CLEAR_ROW = 2'd2;
    localparam logic [1:0] S_CLEAR_ALL = 2'd3;

    localparam logic [6:0] LAST_COL = 7'(COLS - 1);
    localparam logic [4:0] LAST_ROW = 5'(ROWS - 1);

    logic [1:0] r_state;
    logic       r_in_ready;
    logic       r_wr_valid;
    logic [4:0] r_wr_row;
    logic [6:0] r_wr_col;
    logic [7:0] r_wr_char;
    logic [4:0] r_top_row;
    logic [4:0] r_cur_row;
    logic [6:0] r_cur_col;

    logic       w_accept;
    logic       w_done;
    logic       w_printable;
    logic [4:0] w_next_row;
    logic [4:0] w_next_top;

    assign w_accept    = r_in_ready & bus.in_valid;
    assign w_done      = r_wr_valid & bus.vram_write_ready;
    assign w_printable = (bus.in_char >= 8'h20) && (bus.in_char <= 8'h7E);
    assign w_next_row  = (r_cur_row == LAST_ROW) ? 5'd0 : r_cur_row + 5'd1;
    assign w_next_top  = (r_top_row == LAST_ROW) ? 5'd0 : r_top_row + 5'd1;

    always_ff @(posedge clk or negedge reset_low) begin
        if (!reset_low) begin
            r_state    <= S_IDLE;
            r_in_ready <= 1'b1;
            r_wr_valid <= 1'b0;
            r_wr_row   <= 5'd0;
            r_wr_col   <= 7'd0;
            r_wr_char  <= BLANK;
            r_top_row  <= 5'd0;
            r_cur_row  <= 5'd0;
            r_cur_col  <= 7'd0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_accept) begin
                        r_in_ready <= 1'b0;
                        if (w_printable) begin
                            r_state    <= S_PUT;
                            r_wr_valid <= 1'b1;
                            r_wr_row   <= r_cur_row;
                            r_wr_col   <= r_cur_col;
                            r_wr_char  <= bus.in_char;
                        end else begin
                            case (bus.in_char)
                                8'h0D: r_cur_col <= 7'd0;
                                8'h08: if (r_cur_col != 7'd0) r_cur_col <= r_cur_col - 7'd1;
                                8'h0A: begin
                                    // The new line overwrites the oldest visible row, so scroll when they meet.
                                    r_cur_row <= w_next_row;
                                    if (w_next_row == r_top_row) r_top_row <= w_next_top;
                                    r_state    <= S_CLEAR_ROW;
                                    r_wr_valid <= 1'b1;
                                    r_wr_row   <= w_next_row;
                                    r_wr_col   <= 7'd0;
                                    r_wr_char  <= BLANK;
                                end
                                8'h0C: begin
                                    r_state    <= S_CLEAR_ALL;
                                    r_wr_valid <= 1'b1;
                                    r_wr_row   <= 5'd0;
                                    r_wr_col   <= 7'd0;
                                    r_wr_char  <= BLANK;
                                end
                                default: ;
                            endcase
                        end
                    end else begin
                        r_in_ready <= 1'b1;
                    end
                end
                S_PUT: begin
                    if (w_done) begin
                        if (r_cur_col < LAST_COL) begin
                            r_cur_col  <= r_cur_col + 7'd1;
                            r_wr_valid <= 1'b0;
                            r_in_ready <= 1'b1;
                            r_state    <= S_IDLE;
                        end else begin
                            r_cur_col <= 7'd0;
                            r_cur_row <= w_next_row;
                            if (w_next_row == r_top_row) r_top_row <= w_next_top;
                            r_state   <= S_CLEAR_ROW;
                            r_wr_row  <= w_next_row;
                            r_wr_col  <= 7'd0;
                            r_wr_char <= BLANK;
                        end
                    end
                end
                S_CLEAR_ROW: begin
                    if (w_done) begin
                        if (r_wr_col == LAST_COL) begin
                            r_wr_valid <= 1'b0;
                            r_in_ready <= 1'b1;
                            r_state    <= S_IDLE;
                        end else begin
                            r_wr_col <= r_wr_col + 7'd1;
                        end
                    end
                end
                S_CLEAR_ALL: begin
                    if (w_done) begin
                        if (r_wr_col != LAST_COL) begin
                            r_wr_col <= r_wr_col + 7'd1;
                        end else begin
                            r_wr_col <= 7'd0;
                            if (r_wr_row == LAST_ROW) begin
                                r_wr_row   <= 5'd0;
                                r_wr_valid <= 1'b0;
                                r_in_ready <= 1'b1;
                                r_cur_row  <= 5'd0;
                                r_cur_col  <= 7'd0;
                                r_top_row  <= 5'd0;
                                r_state    <= S_IDLE;
                            end else begin
                                r_wr_row <= r_wr_row + 5'd1;
                            end
                        end
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign bus.in_ready         = r_in_ready;
    assign bus.vram_write_valid = r_wr_valid;
    assign bus.vram_write_row   = r_wr_row;
    assign bus.vram_write_col   = r_wr_col;
    assign bus.vram_write_char  = r_wr_char;
    assign top_row              = r_top_row;
    assign cursor_row           = r_cur_row;
    assign cursor_col           = r_cur_col;

endmodule
